// File: rtl/modexp_ctrl_pkg.sv
// Shared types for the modular-exponentiation sequencer.
package modexp_ctrl_pkg;

  localparam int unsigned SIZE_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_SCAN,
    S_MUL,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  // Which modulo operation is currently in flight
  typedef enum logic [1:0] {
    OP_SQR,
    OP_MULB,
    OP_RED
  } op_e;

endpackage

// File: rtl/modexp_ctrl_if.sv
// Command/result streams plus the modulo-unit streams of the sequencer.
interface modexp_ctrl_if
  import modexp_ctrl_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEF
);

  logic [3*SIZE-1:0] cmd_tdata;
  logic              cmd_tvalid;
  logic              cmd_tready;
  logic [SIZE-1:0]   res_tdata;
  logic              res_tvalid;
  logic              res_tready;
  logic              res_err;
  logic [2*SIZE-1:0] mod_dividen_tdata;
  logic              mod_dividen_tvalid;
  logic              mod_dividen_tready;
  logic [SIZE-1:0]   mod_divisor_tdata;
  logic              mod_divisor_tvalid;
  logic              mod_divisor_tready;
  logic [SIZE-1:0]   mod_rem_tdata;
  logic              mod_rem_tvalid;
  logic              mod_rem_tready;

  modport master (
    input  cmd_tdata, cmd_tvalid, res_tready,
    input  mod_dividen_tready, mod_divisor_tready, mod_rem_tdata, mod_rem_tvalid,
    output cmd_tready, res_tdata, res_tvalid, res_err,
    output mod_dividen_tdata, mod_dividen_tvalid, mod_divisor_tdata, mod_divisor_tvalid,
    output mod_rem_tready
  );

  modport slave (
    output cmd_tdata, cmd_tvalid, res_tready,
    output mod_dividen_tready, mod_divisor_tready, mod_rem_tdata, mod_rem_tvalid,
    input  cmd_tready, res_tdata, res_tvalid, res_err,
    input  mod_dividen_tdata, mod_dividen_tvalid, mod_divisor_tdata, mod_divisor_tvalid,
    input  mod_rem_tready
  );

endinterface

// File: rtl/modexp_ctrl_mul.sv
// Registered SIZE x SIZE unsigned multiplier, one-cycle latency, full-width product.
module modexp_ctrl_mul #(
  parameter int unsigned SIZE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [SIZE-1:0]   i_a,
  input  logic [SIZE-1:0]   i_b,
  output logic              o_valid,
  output logic [2*SIZE-1:0] o_p
);

  // Product register holds its value until the next valid input
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_p     <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_p <= (2*SIZE)'(i_a) * (2*SIZE)'(i_b);
    end
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external modulo unit.
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  modexp_ctrl_if.master bus,
  output logic          busy
);

  localparam int unsigned IDXW = $clog2(SIZE);
  localparam int unsigned PW   = 2 * SIZE;

  state_e            r_state, w_state_nxt;
  op_e               r_op, w_op_nxt;
  logic [SIZE-1:0]   r_acc, w_acc_nxt;
  logic [SIZE-1:0]   r_base, w_base_nxt;
  logic [SIZE-1:0]   r_exp, w_exp_nxt;
  logic [SIZE-1:0]   r_m, w_m_nxt;
  logic [IDXW-1:0]   r_idx, w_idx_nxt;
  logic              r_started, w_started_nxt;
  logic              r_err, w_err_nxt;
  logic              r_dvd_valid, w_dvd_valid_nxt;
  logic              r_dvs_valid, w_dvs_valid_nxt;
  logic              r_cmd_ready, r_busy, r_rem_ready, r_res_valid;
  logic              w_adv;
  logic              w_mul_valid;
  logic [SIZE-1:0]   w_mul_a, w_mul_b;
  logic              w_prod_valid;
  logic [PW-1:0]     w_prod;

  wire w_cmd_hs = bus.cmd_tvalid & r_cmd_ready;
  wire w_res_hs = r_res_valid & bus.res_tready;
  wire w_dvd_hs = r_dvd_valid & bus.mod_dividen_tready;
  wire w_dvs_hs = r_dvs_valid & bus.mod_divisor_tready;
  wire w_rem_hs = bus.mod_rem_tvalid & r_rem_ready;
  wire w_issuing = (r_state == S_REDUCE) || (r_state == S_ISSUE);
  // Product lands one cycle into the issue state; both streams must then have transferred
  wire w_issue_done = w_issuing & ~w_prod_valid & (~r_dvd_valid | w_dvd_hs) & (~r_dvs_valid | w_dvs_hs);

  wire [SIZE-1:0] w_base_in = bus.cmd_tdata[SIZE-1:0];
  wire [SIZE-1:0] w_exp_in  = bus.cmd_tdata[2*SIZE-1:SIZE];
  wire [SIZE-1:0] w_m_in    = bus.cmd_tdata[3*SIZE-1:2*SIZE];

  // The multiplier output register is the dividend source; REDUCE loads it with base*1
  modexp_ctrl_mul #(.SIZE(SIZE)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_mul_valid),
    .i_a     (w_mul_a),
    .i_b     (w_mul_b),
    .o_valid (w_prod_valid),
    .o_p     (w_prod)
  );

  // Next-state, datapath updates and multiplier launch
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_acc_nxt     = r_acc;
    w_base_nxt    = r_base;
    w_exp_nxt     = r_exp;
    w_m_nxt       = r_m;
    w_idx_nxt     = r_idx;
    w_started_nxt = r_started;
    w_err_nxt     = r_err;
    w_adv         = 1'b0;
    w_mul_valid   = 1'b0;
    w_mul_a       = r_acc;
    w_mul_b       = r_acc;

    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) begin
          w_exp_nxt     = w_exp_in;
          w_m_nxt       = w_m_in;
          w_base_nxt    = '0;
          w_idx_nxt     = IDXW'(SIZE - 1);
          w_started_nxt = 1'b0;
          w_op_nxt      = OP_RED;
          w_err_nxt     = 1'b0;
          w_acc_nxt     = '0;
          w_mul_valid   = 1'b1;
          w_mul_a       = w_base_in;
          w_mul_b       = SIZE'(1);
          if (w_m_in == '0) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else if (w_m_in == SIZE'(1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_acc_nxt   = SIZE'(1);
            w_state_nxt = S_REDUCE;
          end
        end
      end
      S_REDUCE, S_ISSUE: begin
        if (w_issue_done) w_state_nxt = S_WAIT;
      end
      S_SCAN: begin
        if (r_started) begin
          w_op_nxt    = OP_SQR;
          w_state_nxt = S_MUL;
        end else if (r_exp[r_idx]) begin
          w_started_nxt = 1'b1;
          w_acc_nxt     = r_base;
          w_adv         = 1'b1;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_MUL: begin
        w_mul_valid = 1'b1;
        w_mul_b     = (r_op == OP_MULB) ? r_base : r_acc;
        w_state_nxt = S_ISSUE;
      end
      S_WAIT: begin
        if (w_rem_hs) begin
          if (r_op == OP_RED) begin
            w_base_nxt  = bus.mod_rem_tdata;
            w_state_nxt = S_SCAN;
          end else begin
            w_acc_nxt = bus.mod_rem_tdata;
            if ((r_op == OP_SQR) && r_exp[r_idx]) begin
              w_op_nxt    = OP_MULB;
              w_state_nxt = S_MUL;
            end else begin
              w_adv = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (w_res_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_adv) begin
      if (r_idx == '0) begin
        w_state_nxt = S_DONE;
      end else begin
        w_idx_nxt   = r_idx - IDXW'(1);
        w_state_nxt = S_SCAN;
      end
    end

    w_dvd_valid_nxt = (w_prod_valid & w_issuing) | (r_dvd_valid & ~w_dvd_hs);
    w_dvs_valid_nxt = (w_prod_valid & w_issuing) | (r_dvs_valid & ~w_dvs_hs);
  end

  // State and datapath registers; status outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_SQR;
      r_acc       <= '0;
      r_base      <= '0;
      r_exp       <= '0;
      r_m         <= '0;
      r_idx       <= '0;
      r_started   <= 1'b0;
      r_err       <= 1'b0;
      r_dvd_valid <= 1'b0;
      r_dvs_valid <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rem_ready <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_acc       <= w_acc_nxt;
      r_base      <= w_base_nxt;
      r_exp       <= w_exp_nxt;
      r_m         <= w_m_nxt;
      r_idx       <= w_idx_nxt;
      r_started   <= w_started_nxt;
      r_err       <= w_err_nxt;
      r_dvd_valid <= w_dvd_valid_nxt;
      r_dvs_valid <= w_dvs_valid_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rem_ready <= (w_state_nxt == S_WAIT);
      r_res_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.cmd_tready         = r_cmd_ready;
  assign bus.res_tdata          = r_acc;
  assign bus.res_tvalid         = r_res_valid;
  assign bus.res_err            = r_err;
  assign bus.mod_dividen_tdata  = w_prod;
  assign bus.mod_dividen_tvalid = r_dvd_valid;
  assign bus.mod_divisor_tdata  = r_m;
  assign bus.mod_divisor_tvalid = r_dvs_valid;
  assign bus.mod_rem_tready     = r_rem_ready;
  assign busy                   = r_busy;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl paired with a behavioural modulo unit.
module tb_modexp_ctrl;

  localparam int unsigned SIZE = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  bit   skew = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   op_count = 0;

  always #5 clk = ~clk;

  modexp_ctrl_if #(.SIZE(SIZE)) bus ();

  modexp_ctrl #(.SIZE(SIZE)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Behavioural modulo unit with random readiness and latency
  logic [2*SIZE-1:0] m_dvd;
  logic [SIZE-1:0]   m_dvs;
  logic              m_got_dvd, m_got_dvs;
  int                m_lat;

  always @(posedge clk) begin
    if (rst) begin
      m_got_dvd              <= 1'b0;
      m_got_dvs              <= 1'b0;
      m_lat                  <= 0;
      bus.mod_rem_tvalid     <= 1'b0;
      bus.mod_rem_tdata      <= '0;
      bus.mod_dividen_tready <= 1'b0;
      bus.mod_divisor_tready <= 1'b0;
    end else begin
      if (bus.mod_dividen_tvalid && bus.mod_dividen_tready) begin
        m_dvd     <= bus.mod_dividen_tdata;
        m_got_dvd <= 1'b1;
      end
      if (bus.mod_divisor_tvalid && bus.mod_divisor_tready) begin
        m_dvs     <= bus.mod_divisor_tdata;
        m_got_dvs <= 1'b1;
      end
      if (m_got_dvd && m_got_dvs && !bus.mod_rem_tvalid) begin
        if (m_lat == 0) begin
          bus.mod_rem_tdata  <= SIZE'(m_dvd % (2*SIZE)'(m_dvs));
          bus.mod_rem_tvalid <= 1'b1;
          m_got_dvd          <= 1'b0;
          m_got_dvs          <= 1'b0;
          op_count           <= op_count + 1;
          m_lat              <= int'($urandom_range(0, 2));
        end else begin
          m_lat <= m_lat - 1;
        end
      end
      if (bus.mod_rem_tvalid && bus.mod_rem_tready) bus.mod_rem_tvalid <= 1'b0;
      if (skew) begin
        bus.mod_dividen_tready <= 1'b1;
        bus.mod_divisor_tready <= m_got_dvd;
      end else begin
        bus.mod_dividen_tready <= 1'($urandom_range(0, 1));
        bus.mod_divisor_tready <= 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: right-to-left exponentiation, plus the number of modulo ops the sequencer must issue
  function automatic void ref_model(input logic [SIZE-1:0] b, input logic [SIZE-1:0] e,
                                    input logic [SIZE-1:0] m, output logic [SIZE-1:0] r,
                                    output logic err, output int ops);
    logic [63:0] x, y, ee, mm;
    int msb, pop;
    err = (m == 0);
    r   = '0;
    ops = 0;
    if (m > 1) begin
      mm = 64'(m);
      x  = 64'(b) % mm;
      y  = 1;
      ee = 64'(e);
      while (ee != 0) begin
        if (ee[0]) y = (y * x) % mm;
        x  = (x * x) % mm;
        ee = ee >> 1;
      end
      r   = SIZE'(y);
      msb = 0;
      pop = 0;
      for (int i = 0; i < int'(SIZE); i++) begin
        if (e[i]) begin
          msb = i;
          pop++;
        end
      end
      ops = (e == 0) ? 1 : msb + pop;
    end
  endfunction

  task automatic send(input logic [SIZE-1:0] b, input logic [SIZE-1:0] e, input logic [SIZE-1:0] m);
    int n = 0;
    @(negedge clk);
    bus.cmd_tdata  = {m, e, b};
    bus.cmd_tvalid = 1'b1;
    while (!bus.cmd_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.cmd_tvalid = 1'b0;
  endtask

  task automatic run(input logic [SIZE-1:0] b, input logic [SIZE-1:0] e,
                     input logic [SIZE-1:0] m, input bit hold);
    logic [SIZE-1:0] er, first;
    logic            ee, stable;
    int              eops, ops0, n;
    ref_model(b, e, m, er, ee, eops);
    ops0 = op_count;
    bus.res_tready = !hold;
    send(b, e, m);
    n = 0;
    @(negedge clk);
    while (!bus.res_tvalid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("res_valid", 64'(bus.res_tvalid), 64'(1));
    check($sformatf("res %0d^%0d mod %0d", b, e, m), 64'(bus.res_tdata), 64'(er));
    check("res_err", 64'(bus.res_err), 64'(ee));
    if (hold) begin
      first  = bus.res_tdata;
      stable = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (!(bus.res_tvalid && bus.res_tdata == first && !bus.cmd_tready)) stable = 1'b0;
      end
      check("hold_stable", 64'(stable), 64'(1));
      bus.res_tready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("res_consumed", 64'(bus.res_tvalid), 64'(0));
    check("cmd_ready_after", 64'(bus.cmd_tready), 64'(1));
    check("mod_ops", 64'(op_count - ops0), 64'(eops));
  endtask

  initial begin
    int n;
    logic [SIZE-1:0] rb, re, rm;
    rst            = 1'b1;
    bus.cmd_tvalid = 1'b0;
    bus.cmd_tdata  = '0;
    bus.res_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(bus.cmd_tready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_res_valid", 64'(bus.res_tvalid), 64'(0));
    check("rst_res_data", 64'(bus.res_tdata), 64'(0));
    check("rst_res_err", 64'(bus.res_err), 64'(0));
    check("rst_dvd_valid", 64'(bus.mod_dividen_tvalid), 64'(0));
    check("rst_dvs_valid", 64'(bus.mod_divisor_tvalid), 64'(0));
    check("rst_rem_ready", 64'(bus.mod_rem_tready), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run(3, 5, 7, 0);
    run(2, 10, 1000, 0);
    run(1000, 3, 13, 0);
    run(5, 3, 13, 0);
    run(9, 0, 13, 0);
    run(1234, 567, 1, 0);
    run(77, 8, 0, 0);
    run(65535, 1, 65535, 0);
    run(3, 5, 7, 1);

    skew = 1'b1;
    run(2, 10, 1000, 0);
    run(12345, 65535, 65521, 0);
    skew = 1'b0;

    // Abort while waiting on a remainder
    send(3, 5, 7);
    n = 0;
    while (!bus.mod_rem_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_wait", 64'(bus.mod_rem_tready), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_cmd_ready", 64'(bus.cmd_tready), 64'(1));
    check("abort_dvd_valid", 64'(bus.mod_dividen_tvalid), 64'(0));
    check("abort_dvs_valid", 64'(bus.mod_divisor_tvalid), 64'(0));
    check("abort_res_valid", 64'(bus.res_tvalid), 64'(0));
    check("abort_rem_ready", 64'(bus.mod_rem_tready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run(3, 5, 7, 0);

    for (int i = 0; i < 250; i++) begin
      rb = SIZE'($urandom);
      re = SIZE'($urandom);
      rm = ($urandom_range(0, 7) == 0) ? SIZE'($urandom_range(0, 3)) : SIZE'($urandom);
      run(rb, re, rm, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
